// File: rtl/vga_pkg.sv
// Shared definitions for the VGA sync path: count widths, default 640x480@60 timing
// and the vertical-region encoding.
package vga_pkg;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned FCNT_W = 8;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    VS_ACTIVE = 2'd0,
    VS_FRONT  = 2'd1,
    VS_SYNC   = 2'd2,
    VS_BACK   = 2'd3
  } vstate_e;

  // Expected successor of a vertical region within a well-formed frame.
  function automatic vstate_e vstate_next(input vstate_e s);
    case (s)
      VS_ACTIVE: vstate_next = VS_FRONT;
      VS_FRONT:  vstate_next = VS_SYNC;
      VS_SYNC:   vstate_next = VS_BACK;
      default:   vstate_next = VS_ACTIVE;
    endcase
  endfunction

endpackage

// File: rtl/vga_region_decode.sv
// Combinational map from raw (h,v) counts to sync levels, active window,
// vertical region and an out-of-range indication.
module vga_region_decode
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic [CNT_W-1:0] h,
  input  logic [CNT_W-1:0] v,
  output logic             hsync_n_c,
  output logic             vsync_n_c,
  output logic             active_c,
  output vstate_e          vregion_c,
  output logic             out_of_range_c
);

  localparam int unsigned H_SS_I  = H_ACTIVE + H_FP;
  localparam int unsigned H_SE_I  = H_SS_I + H_SYNC;
  localparam int unsigned H_TOT_I = H_SE_I + H_BP;
  localparam int unsigned V_SS_I  = V_ACTIVE + V_FP;
  localparam int unsigned V_SE_I  = V_SS_I + V_SYNC;
  localparam int unsigned V_TOT_I = V_SE_I + V_BP;

  localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS  = CNT_W'(H_SS_I);
  localparam logic [CNT_W-1:0] H_SE  = CNT_W'(H_SE_I);
  localparam logic [CNT_W-1:0] H_TOT = CNT_W'(H_TOT_I);
  localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SS  = CNT_W'(V_SS_I);
  localparam logic [CNT_W-1:0] V_SE  = CNT_W'(V_SE_I);
  localparam logic [CNT_W-1:0] V_TOT = CNT_W'(V_TOT_I);

  assign hsync_n_c      = !((h >= H_SS) && (h < H_SE));
  assign vsync_n_c      = !((v >= V_SS) && (v < V_SE));
  assign active_c       = (h < H_ACT) && (v < V_ACT);
  assign out_of_range_c = (h >= H_TOT) || (v >= V_TOT);

  always_comb begin
    vregion_c = VS_BACK;
    if (v < V_ACT)     vregion_c = VS_ACTIVE;
    else if (v < V_SS) vregion_c = VS_FRONT;
    else if (v < V_SE) vregion_c = VS_SYNC;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Registered VGA sync/blanking stage with vertical-region tracking and sticky error flag.
// Optional frame counter port enabled by defining VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic [CNT_W-1:0]  h_count,
  input  logic [CNT_W-1:0]  v_count,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic [CNT_W-1:0]  x,
  output logic [CNT_W-1:0]  y,
  output logic              line_start,
  output logic              frame_start,
  output logic [1:0]        vstate,
`ifdef VGA_SYNC_FRAME_CNT_EN
  output logic [FCNT_W-1:0] frame_cnt,
`endif
  output logic              timing_err
);

  logic    hsync_n_c, vsync_n_c, active_c, out_of_range_c;
  vstate_e vregion_c;

  vga_region_decode #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_decode (
    .h              (h_count),
    .v              (v_count),
    .hsync_n_c      (hsync_n_c),
    .vsync_n_c      (vsync_n_c),
    .active_c       (active_c),
    .vregion_c      (vregion_c),
    .out_of_range_c (out_of_range_c)
  );

  logic             hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic             timing_err_q, timing_err_d, first_q, first_d;
  vstate_e          vstate_q, vstate_d;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
`endif

  // Next-state: levels hold without pix_en; first valid sample after reset skips the sequence check.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    timing_err_d  = timing_err_q;
    first_d       = first_q;
    vstate_d      = vstate_q;
`ifdef VGA_SYNC_FRAME_CNT_EN
    frame_cnt_d   = frame_cnt_q;
`endif
    if (pix_en) begin
      if (out_of_range_c) begin
        hsync_d      = 1'b1;
        vsync_d      = 1'b1;
        video_on_d   = 1'b0;
        x_d          = '0;
        y_d          = '0;
        timing_err_d = 1'b1;
      end else begin
        hsync_d       = hsync_n_c;
        vsync_d       = vsync_n_c;
        video_on_d    = active_c;
        x_d           = active_c ? h_count : '0;
        y_d           = active_c ? v_count : '0;
        line_start_d  = (h_count == '0);
        frame_start_d = (h_count == '0) && (v_count == '0);
        if (!first_q && (vregion_c != vstate_q) && (vregion_c != vstate_next(vstate_q)))
          timing_err_d = 1'b1;
        vstate_d      = vregion_c;
        first_d       = 1'b0;
`ifdef VGA_SYNC_FRAME_CNT_EN
        if (frame_start_d) frame_cnt_d = frame_cnt_q + FCNT_W'(1);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      timing_err_q  <= 1'b0;
      first_q       <= 1'b1;
      vstate_q      <= VS_ACTIVE;
`ifdef VGA_SYNC_FRAME_CNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      timing_err_q  <= timing_err_d;
      first_q       <= first_d;
      vstate_q      <= vstate_d;
`ifdef VGA_SYNC_FRAME_CNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign vstate      = vstate_q;
  assign timing_err  = timing_err_q;
`ifdef VGA_SYNC_FRAME_CNT_EN
  assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: reference model pushes expected outputs per sample,
// popped and compared one clk later.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en = 1'b0;
  logic [9:0] h_count = '0;
  logic [9:0] v_count = '0;
  logic       hsync, vsync, video_on, line_start, frame_start, timing_err;
  logic [9:0] x, y;
  logic [1:0] vstate;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  vga_sync_gen dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h_count(h_count), .v_count(v_count),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start), .vstate(vstate),
`ifdef VGA_SYNC_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .timing_err(timing_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hs, vs, von;
    logic [9:0] x, y;
    logic       ls, fs;
    logic [1:0] vst;
    logic       err;
    logic [7:0] fc;
  } exp_t;

  exp_t q[$];
  exp_t m, prev;
  logic m_first;
  bit   have_prev = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour written directly from the 640x480 timing numbers.
  task automatic model(input logic r, input logic pe, input logic [9:0] h, input logic [9:0] v);
    logic [1:0] reg_v;
    if (r) begin
      m = '{hs:1'b1, vs:1'b1, von:1'b0, x:10'd0, y:10'd0, ls:1'b0, fs:1'b0,
            vst:2'd0, err:1'b0, fc:8'd0};
      m_first = 1'b1;
    end else if (!pe) begin
      m.ls = 1'b0;
      m.fs = 1'b0;
    end else if (h >= 10'd800 || v >= 10'd525) begin
      m.err = 1'b1;
      m.hs = 1'b1; m.vs = 1'b1; m.von = 1'b0; m.x = 10'd0; m.y = 10'd0;
      m.ls = 1'b0; m.fs = 1'b0;
    end else begin
      m.hs  = !(h >= 10'd656 && h <= 10'd751);
      m.vs  = !(v == 10'd490 || v == 10'd491);
      m.von = (h < 10'd640) && (v < 10'd480);
      m.x   = m.von ? h : 10'd0;
      m.y   = m.von ? v : 10'd0;
      m.ls  = (h == 10'd0);
      m.fs  = (h == 10'd0) && (v == 10'd0);
      if (v < 10'd480) reg_v = 2'd0;
      else if (v < 10'd490) reg_v = 2'd1;
      else if (v < 10'd492) reg_v = 2'd2;
      else reg_v = 2'd3;
      if (!m_first && reg_v != m.vst && reg_v != 2'(m.vst + 2'd1)) m.err = 1'b1;
      m.vst = reg_v;
      m_first = 1'b0;
`ifdef VGA_SYNC_FRAME_CNT_EN
      if (m.fs) m.fc = m.fc + 8'd1;
`endif
    end
  endtask

  task automatic compare(input exp_t e);
    chk("hsync", 32'(hsync), 32'(e.hs));
    chk("vsync", 32'(vsync), 32'(e.vs));
    chk("video_on", 32'(video_on), 32'(e.von));
    chk("x", 32'(x), 32'(e.x));
    chk("y", 32'(y), 32'(e.y));
    chk("line_start", 32'(line_start), 32'(e.ls));
    chk("frame_start", 32'(frame_start), 32'(e.fs));
    chk("vstate", 32'(vstate), 32'(e.vst));
    chk("timing_err", 32'(timing_err), 32'(e.err));
`ifdef VGA_SYNC_FRAME_CNT_EN
    chk("frame_cnt", 32'(frame_cnt), 32'(e.fc));
`endif
  endtask

  // One sample: drive at negedge, confirm no combinational response, compare after the edge.
  task automatic step(input logic r, input logic pe, input logic [9:0] h, input logic [9:0] v);
    exp_t e;
    @(negedge clk);
    rst = r; pix_en = pe; h_count = h; v_count = v;
    model(r, pe, h, v);
    q.push_back(m);
    #1;
    if (have_prev) begin
      chk("pre_edge_x", 32'(x), 32'(prev.x));
      chk("pre_edge_video_on", 32'(video_on), 32'(prev.von));
    end
    @(posedge clk);
    #1;
    e = q.pop_front();
    compare(e);
    prev = e;
    have_prev = 1;
  endtask

  task automatic run_line(input logic [9:0] v);
    int hs_low = 0;
    int first_low = -1;
    int von_cnt = 0;
    for (int h = 0; h < 800; h++) begin
      step(1'b0, 1'b1, 10'(h), v);
      if (hsync === 1'b0) begin
        if (first_low < 0) first_low = h;
        hs_low++;
      end
      if (video_on === 1'b1) von_cnt++;
    end
    chk("hsync_low_count", 32'(hs_low), 32'd96);
    chk("hsync_first_low", 32'(first_low), 32'd656);
    chk("video_on_count", 32'(von_cnt), (v < 10'd480) ? 32'd640 : 32'd0);
  endtask

  initial begin
    logic [9:0] lines[11];
    lines = '{10'd0, 10'd1, 10'd479, 10'd480, 10'd489, 10'd490, 10'd491,
              10'd492, 10'd524, 10'd0, 10'd1};

    step(1'b1, 1'b0, 10'd0, 10'd0);
    step(1'b1, 1'b1, 10'd5, 10'd5);
    chk("reset_hsync", 32'(hsync), 32'd1);
    chk("reset_vstate", 32'(vstate), 32'd0);

    // Sweep lines across every vertical region, including the 524->0 wrap.
    foreach (lines[i]) begin
      run_line(lines[i]);
      chk("vsync_level", 32'(vsync), (lines[i] == 10'd490 || lines[i] == 10'd491) ? 32'd0 : 32'd1);
    end
    chk("sweep_timing_err", 32'(timing_err), 32'd0);

    step(1'b0, 1'b1, 10'd639, 10'd479);
    chk("edge_von_639", 32'(video_on), 32'd1);
    chk("edge_x_639", 32'(x), 32'd639);
    step(1'b0, 1'b1, 10'd640, 10'd479);
    chk("edge_von_640", 32'(video_on), 32'd0);
    chk("edge_x_640", 32'(x), 32'd0);

    step(1'b0, 1'b1, 10'd0, 10'd0);
    chk("origin_frame_start", 32'(frame_start), 32'd1);
    chk("origin_line_start", 32'(line_start), 32'd1);
    step(1'b0, 1'b1, 10'd300, 10'd5);
    chk("after_origin_frame_start", 32'(frame_start), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 10'd700, 10'd600);
      chk("hold_x", 32'(x), 32'd300);
      chk("hold_y", 32'(y), 32'd5);
    end
    step(1'b0, 1'b1, 10'd0, 10'd0);
    step(1'b0, 1'b0, 10'd0, 10'd0);
    chk("pulse_drop_line_start", 32'(line_start), 32'd0);

    step(1'b0, 1'b1, 10'd0, 10'd100);
    step(1'b0, 1'b1, 10'd0, 10'd491);
    chk("jump_timing_err", 32'(timing_err), 32'd1);
    chk("jump_vstate", 32'(vstate), 32'd2);
    step(1'b0, 1'b1, 10'd900, 10'd491);
    chk("oor_hsync", 32'(hsync), 32'd1);
    chk("oor_vsync", 32'(vsync), 32'd1);
    chk("oor_vstate_hold", 32'(vstate), 32'd2);
    step(1'b0, 1'b1, 10'd0, 10'd492);
    step(1'b0, 1'b1, 10'd1, 10'd492);
    chk("sticky_err", 32'(timing_err), 32'd1);

    step(1'b1, 1'b1, 10'd10, 10'd300);
    chk("midframe_reset_err", 32'(timing_err), 32'd0);
    chk("midframe_reset_vstate", 32'(vstate), 32'd0);
    for (int h = 0; h < 20; h++) step(1'b0, 1'b1, 10'(h), 10'd301);
    chk("resume_no_err", 32'(timing_err), 32'd0);

`ifdef VGA_SYNC_FRAME_CNT_EN
    step(1'b1, 1'b0, 10'd0, 10'd0);
    for (int i = 1; i <= 256; i++) begin
      step(1'b0, 1'b1, 10'd0, 10'd0);
      if (i == 255) chk("frame_cnt_255", 32'(frame_cnt), 32'd255);
      if (i == 256) chk("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
